// File: rtl/ace_pkg.sv
// Shared state encoding for the single-line ACE coherency controller.
// Encoding 2'd3 is never entered deliberately; the controller recovers it to INVALID.
package ace_pkg;

    typedef enum logic [1:0] {
        INVALID      = 2'd0,
        UNIQUE_DIRTY = 2'd1,
        UNIQUE_CLEAN = 2'd2,
        ILLEGAL      = 2'd3
    } ace_state_e;

endpackage : ace_pkg

// File: rtl/ace_3state_fsm.sv
// Tracks one cache line through INVALID / UNIQUE_DIRTY / UNIQUE_CLEAN and issues
// one-cycle memory/cache action strobes combinationally from state and handshakes.
module ace_3state_fsm
    import ace_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic acvalid,
    input  logic awvalid,
    input  logic arvalid,
    input  logic crready,
    input  logic acsnoop,
    output logic invalid,
    output logic unique_dirty,
    output logic unique_clean,
    output logic write_main_mem,
    output logic write_cache,
    output logic read_main_mem,
    output logic read_cache
);

    ace_state_e r_state;
    ace_state_e w_state_next;
    logic       w_write_main_mem;
    logic       w_write_cache;
    logic       w_read_main_mem;
    logic       w_read_cache;

    // rst_n is active-high despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= INVALID;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Rows within each state are tested in priority order; first match wins.
    always_comb begin
        w_state_next     = r_state;
        w_write_main_mem = 1'b0;
        w_write_cache    = 1'b0;
        w_read_main_mem  = 1'b0;
        w_read_cache     = 1'b0;

        case (r_state)
            INVALID: begin
                if (acvalid) begin
                    w_write_cache = 1'b1;
                    w_state_next  = UNIQUE_DIRTY;
                end else if (arvalid) begin
                    w_read_main_mem = 1'b1;
                    w_state_next    = UNIQUE_CLEAN;
                end
            end
            UNIQUE_DIRTY: begin
                if (acsnoop) begin
                    w_write_main_mem = 1'b1;
                    w_state_next     = UNIQUE_CLEAN;
                end else if (arvalid && crready) begin
                    w_read_cache = 1'b1;
                end else if (awvalid) begin
                    w_write_cache = 1'b1;
                end
            end
            UNIQUE_CLEAN: begin
                if (awvalid && acvalid) begin
                    w_write_cache = 1'b1;
                    w_state_next  = UNIQUE_DIRTY;
                end else if (arvalid && crready) begin
                    w_read_cache = 1'b1;
                end else if (acsnoop && acvalid && !awvalid) begin
                    w_state_next = INVALID;
                end
            end
            default: begin
                w_state_next = INVALID;
            end
        endcase

        // Reset wins over any transition and suppresses this cycle's strobe.
        if (rst_n) begin
            w_state_next     = INVALID;
            w_write_main_mem = 1'b0;
            w_write_cache    = 1'b0;
            w_read_main_mem  = 1'b0;
            w_read_cache     = 1'b0;
        end
    end

    assign write_main_mem = w_write_main_mem;
    assign write_cache    = w_write_cache;
    assign read_main_mem  = w_read_main_mem;
    assign read_cache     = w_read_cache;

    // The illegal encoding reports as INVALID so status stays one-hot.
    assign unique_dirty = (r_state == UNIQUE_DIRTY);
    assign unique_clean = (r_state == UNIQUE_CLEAN);
    assign invalid      = !(unique_dirty || unique_clean);

endmodule : ace_3state_fsm

// File: tb/tb_ace_3state_fsm.sv
// Directed bench for ace_3state_fsm: each step drives inputs after the falling edge
// and checks status (from the previous edge) plus same-cycle strobes.
module tb_ace_3state_fsm;

    logic clk;
    logic rst_n;
    logic acvalid;
    logic awvalid;
    logic arvalid;
    logic crready;
    logic acsnoop;
    logic invalid;
    logic unique_dirty;
    logic unique_clean;
    logic write_main_mem;
    logic write_cache;
    logic read_main_mem;
    logic read_cache;

    int n_cmp;
    int n_err;

    // Expected vector layout: {invalid, unique_dirty, unique_clean,
    //                          write_main_mem, write_cache, read_main_mem, read_cache}
    localparam logic [6:0] INV     = 7'b100_0000;
    localparam logic [6:0] DIRTY   = 7'b010_0000;
    localparam logic [6:0] CLEAN   = 7'b001_0000;
    localparam logic [6:0] WR_MEM  = 7'b000_1000;
    localparam logic [6:0] WR_C    = 7'b000_0100;
    localparam logic [6:0] RD_MEM  = 7'b000_0010;
    localparam logic [6:0] RD_C    = 7'b000_0001;

    ace_3state_fsm dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .acvalid        (acvalid),
        .awvalid        (awvalid),
        .arvalid        (arvalid),
        .crready        (crready),
        .acsnoop        (acsnoop),
        .invalid        (invalid),
        .unique_dirty   (unique_dirty),
        .unique_clean   (unique_clean),
        .write_main_mem (write_main_mem),
        .write_cache    (write_cache),
        .read_main_mem  (read_main_mem),
        .read_cache     (read_cache)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input string tag, input logic r, input logic ac, input logic aw,
                        input logic ar, input logic cr, input logic sn, input logic [6:0] exp);
        logic [6:0] obs;
        @(negedge clk);
        rst_n   = r;
        acvalid = ac;
        awvalid = aw;
        arvalid = ar;
        crready = cr;
        acsnoop = sn;
        #2;
        obs = {invalid, unique_dirty, unique_clean,
               write_main_mem, write_cache, read_main_mem, read_cache};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
        $display("step %-14s rst=%b ac=%b aw=%b ar=%b cr=%b sn=%b -> %b (exp %b)",
                 tag, r, ac, aw, ar, cr, sn, obs, exp);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b1;
        acvalid = 1'b0;
        awvalid = 1'b0;
        arvalid = 1'b0;
        crready = 1'b0;
        acsnoop = 1'b0;
        repeat (2) @(posedge clk);

        //              tag            rst ac  aw  ar  cr  sn  expected
        step("rst_gate",     1, 1, 0, 0, 0, 0, INV);
        step("rst_release",  0, 0, 0, 0, 0, 0, INV);
        step("alloc_dirty",  0, 1, 0, 0, 0, 0, INV | WR_C);
        step("clean_wb",     0, 0, 0, 0, 0, 1, DIRTY | WR_MEM);
        step("clean_hold",   0, 0, 0, 0, 0, 1, CLEAN);
        step("clean_read",   0, 0, 0, 1, 1, 0, CLEAN | RD_C);
        step("clean_nocr",   0, 0, 0, 1, 0, 0, CLEAN);
        step("clean_aw_only",0, 0, 1, 0, 0, 0, CLEAN);
        step("clean_write",  0, 1, 1, 0, 0, 1, CLEAN | WR_C);
        step("dirty_snoop",  0, 1, 1, 0, 0, 1, DIRTY | WR_MEM);
        step("back_clean",   0, 0, 0, 0, 0, 0, CLEAN);
        step("to_dirty",     0, 1, 1, 0, 0, 0, CLEAN | WR_C);
        step("dirty_read",   0, 0, 1, 1, 1, 0, DIRTY | RD_C);
        step("dirty_write",  0, 0, 1, 0, 0, 0, DIRTY | WR_C);
        step("dirty_idle",   0, 0, 0, 1, 0, 0, DIRTY);
        step("dirty_prio",   0, 0, 1, 1, 1, 1, DIRTY | WR_MEM);
        step("snoop_inval",  0, 1, 0, 0, 0, 1, CLEAN);
        step("inval_idle",   0, 0, 0, 0, 0, 0, INV);
        step("fill",         0, 0, 0, 1, 0, 0, INV | RD_MEM);
        step("fill_inval",   0, 1, 0, 0, 0, 1, CLEAN);
        step("rst_mid_inv",  1, 1, 0, 0, 0, 0, INV);
        step("after_rst",    0, 0, 0, 0, 0, 0, INV);
        step("inv_prio",     0, 1, 0, 1, 0, 0, INV | WR_C);
        step("rst_mid_dirty",1, 0, 0, 0, 0, 1, DIRTY);
        step("after_rst2",   0, 0, 0, 0, 0, 0, INV);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ace_3state_fsm

// File: doc/ace_3state_fsm.md
# ace_3state_fsm

Single-line ACE cache-coherency state controller tracking one cache line through three states: INVALID, UNIQUE_DIRTY and UNIQUE_CLEAN. It sits between the ACE snoop/read/write handshake signals and the cache datapath. From the current state and the handshake inputs it issues one-cycle action strobes: read/write main memory, read/write cache. It also exposes the current state as one-hot status outputs.

## Interface
Parameters:
- None. State encoding comes from the shared package.

Ports (all 1 bit):
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous and active-high (asserted when 1), despite the name.
- acvalid  in  1  snoop-address valid; also qualifies write ownership.
- awvalid  in  1  write-address valid (local write request).
- arvalid  in  1  read-address valid (local read request).
- crready  in  1  snoop-response ready; qualifies a cache-hit read.
- acsnoop  in  1  snoop type: 1 = clean/writeback request.
- invalid  out  1  state == INVALID.
- unique_dirty  out  1  state == UNIQUE_DIRTY.
- unique_clean  out  1  state == UNIQUE_CLEAN.
- write_main_mem  out  1  writeback strobe.
- write_cache  out  1  cache write strobe.
- read_main_mem  out  1  line fill from memory strobe.
- read_cache  out  1  cache-hit read strobe.

## Operation
- Status outputs are exactly one-hot and decoded from the state register.
- Action strobes are combinational from the current state and inputs.
  - At most one strobe is high per cycle.
  - All strobes are 0 whenever rst_n = 1.
- Transitions: first matching row in each state wins; otherwise the state holds and no strobe is driven.
- INVALID:
  - acvalid: write_cache=1, next UNIQUE_DIRTY.
  - arvalid: read_main_mem=1, next UNIQUE_CLEAN.
- UNIQUE_DIRTY:
  - acsnoop: write_main_mem=1, next UNIQUE_CLEAN.
  - arvalid & crready: read_cache=1, stay.
  - awvalid: write_cache=1, stay.
- UNIQUE_CLEAN:
  - awvalid & acvalid: write_cache=1, next UNIQUE_DIRTY.
  - arvalid & crready: read_cache=1, stay.
  - acsnoop & acvalid & !awvalid: no strobe, next INVALID (snoop invalidate).
- Simultaneous requests resolve by row priority. Inputs not named in the winning row are ignored.
- acsnoop held high has a repeating effect: UNIQUE_DIRTY cleans back to UNIQUE_CLEAN on the next edge, each time it is entered.

## Timing
- Reset: on a rising edge with rst_n=1, the state becomes INVALID.
  - Outputs: invalid=1, unique_dirty=0, unique_clean=0, all strobes 0.
  - Reset has priority over every transition, including mid-transaction; no strobe is issued in that cycle.
- Strobe latency: 0 cycles. A strobe is valid in the same cycle its inputs are sampled.
- State latency: 1 cycle. The new state is visible one cycle after the qualifying inputs.
- No internal handshake storage. Requests must be held by the master until the strobe is seen.
  - A request dropped before the edge is lost.
- Each qualifying cycle produces one strobe. A request held N cycles in a self-looping row yields N strobes.

## Structure
- Shared package ace_pkg holds:
  - the state typedef (2-bit enum: INVALID=2'd0, UNIQUE_DIRTY=2'd1, UNIQUE_CLEAN=2'd2);
  - the 2'd3 illegal encoding, which must recover to INVALID on the next edge with no strobe.
- Block layout:
  - state register process;
  - combinational next-state/strobe process with defaults assigned first;
  - status decode.
- No sub-module; the block is small enough to stay flat.

## Test plan
- Reset: rst_n=1 for 2 edges, then 0 -> invalid=1, unique_dirty=0, unique_clean=0, all strobes 0.
- Allocate dirty: INVALID, acvalid=1 for 1 cycle -> write_cache=1 that cycle, unique_dirty=1 next cycle.
- Clean: UNIQUE_DIRTY, acsnoop=1 -> write_main_mem=1, unique_clean=1 next cycle. With acsnoop still 1 the state stays UNIQUE_CLEAN and write_main_mem=0.
- Clean read: UNIQUE_CLEAN, arvalid=1 and crready=1 for 1 cycle -> read_cache=1, state unchanged. With arvalid=1 and crready=0 -> no strobe.
- Clean write with snoop pending: UNIQUE_CLEAN, awvalid=1, acvalid=1, acsnoop=1 -> write_cache=1, unique_dirty=1 next cycle, then write_main_mem=1 and unique_clean=1 one cycle later.
- Fill/invalidate/reset-mid: INVALID, arvalid=1 -> read_main_mem=1, then UNIQUE_CLEAN. Then acsnoop=1, acvalid=1 -> invalid=1 next cycle. Then rst_n=1 asserted while acvalid=1 in INVALID -> no strobe, stays INVALID.
